vdg_text_fetch: RTL
===================

# vdg_text_fetch

Text-mode video sequencer that sits directly upstream of the character generator. It runs the raster counters and fetches character codes from video RAM. It drives `char_code`, `subchar_line` and `subchar_pixel` so the generator loads ROM data at `subchar_pixel==5` of every cell. It also produces sync, a display-enable aligned to the generator's serial `pixel_on` output, and a per-frame start pulse for the CPU interrupt.

## Interface
- `H_ACTIVE`, 512: active pixel clocks per line (fixed by 32×16 and 64×8 cell geometry).
- `H_TOTAL`, 640: pixel clocks per line.
- `H_SYNC_START`, 544; `H_SYNC_LEN`, 48: hsync position/length in clocks.
- `V_ACTIVE`, 384: active lines.
- `V_TOTAL`, 420: lines per frame.
- `V_SYNC_START`, 400; `V_SYNC_LEN`, 4: vsync position/length in lines.
- `VRAM_AW`, 11: video RAM address width.
- `DE_DELAY`, 6: clocks from cell start to first `pixel_on` bit.
- `pixel_clock`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `width_64_req`  in  1  requested mode; 1 selects 64×32, 0 selects 32×16.
- `vram_addr`  out  VRAM_AW  video RAM read address (registered).
- `vram_rd`  out  1  read strobe, one clock per active cell.
- `vram_data`  in  8  RAM read data, valid one clock after `vram_addr`/`vram_rd`.
- `char_code`  out  8  latched character code for the character generator.
- `subchar_line`  out  5  line within the character row.
- `subchar_pixel`  out  4  clock position within the cell.
- `width_64`  out  1  mode in effect for the current frame; also drives the generator.
- `hsync`, `vsync`  out  1  active-high syncs.
- `de`  out  1  display enable, delayed `DE_DELAY` clocks.
- `frame_start`  out  1  one-clock pulse at the frame wrap.

## Operation
- `h_count` runs 0..H_TOTAL-1 and wraps. `v_count` runs 0..V_TOTAL-1 and advances on the h wrap.
- Active area is `h_count < H_ACTIVE` and `v_count < V_ACTIVE`.
- 32-column mode:
  - cell = 16 clocks; `subchar_pixel = h_count[3:0]`; col = `h_count[8:4]`.
  - Row height is 24 lines; `subchar_line` runs 0..23.
- 64-column mode:
  - cell = 8 clocks; `subchar_pixel = {1'b0, h_count[2:0]}`; col = `h_count[8:3]`.
  - Row height is 12 lines; `subchar_line` runs 0..11.
- Line and row counters are incremented on the h wrap, never divided. Reaching the last line clears `subchar_line` and increments `row`. Both clear at the v wrap.
- Address: `row*32+col` (32-col) or `row*64+col` (64-col), computed by shift/concat and zero-extended.
- Fetch, active cells only:
  - `subchar_pixel==0`: `vram_addr` is valid and `vram_rd` is high.
  - Edge ending pixel 1: `char_code <= vram_data`.
  - Outside active area: `vram_rd`=0 and `char_code` holds its value.
- Mode latch: `width_64 <= width_64_req` only on the v wrap. A mid-frame change on `width_64_req` has no effect until the next frame.
- `frame_start`: high for the one clock where `h_count==0 && v_count==0`.
- Syncs: `hsync` is high for `H_SYNC_START <= h_count < H_SYNC_START+H_SYNC_LEN`. `vsync` follows the same rule in lines.
- `de`: the active flag passed through a `DE_DELAY`-stage shift register.

## Timing
- Reset values:
  - all counters 0, `vram_addr`=0, `vram_rd`=0;
  - `char_code`=8'h00, `subchar_line`=0, `subchar_pixel`=0;
  - `width_64`=0, `hsync`=0, `vsync`=0, `de`=0 (whole delay line cleared), `frame_start`=0.
- First clock after reset release is `h_count=0`, `v_count=0`, with `frame_start` asserted.
- All outputs are registered. Counter outputs change on the edge that advances the count.
- Per-cell latency:
  - address at pixel 0, RAM data at pixel 1, `char_code` at pixel 2;
  - generator ROM data at pixel 3, load at pixel 5, first `pixel_on` during pixel 6 (hence `DE_DELAY`=6).
- Line wrap and frame wrap on the same edge: `v_count`, row and line clear together, and `width_64` reloads on that edge.
- Reset mid-line: all state returns immediately (asynchronously) to reset values and any in-flight fetch is discarded.

## Structure
- Shared package `vdg_pkg` holds:
  - mode encodings;
  - row-height constants (24 and 12);
  - cell-width constants (16 and 8);
  - the fetch-phase constants (addr=0, latch=1, load=5).
- One sub-module `vdg_raster_counter` provides h/v counters, syncs, active flag and `frame_start`. Fetch, row/line tracking and the `de` delay stay in the top level.

## Test plan
- Reset, then release:
  - `frame_start`=1 on the first clock.
  - `vram_addr`=0 with `vram_rd`=1 at `subchar_pixel`=0.
  - `char_code` equals RAM[0] from pixel 2.
- 32-col mode, RAM[i]=i:
  - cell 5 of line 0 gives `vram_addr`=5.
  - Line 24 gives row 1 and cell 0 gives `vram_addr`=32 with `subchar_line`=0.
- 64-col mode:
  - `subchar_pixel` cycles 0..7.
  - Line 12 cell 3 gives `vram_addr`=67.
  - Line 383 cell 63 gives `vram_addr`=2047.
- Toggle `width_64_req` at line 100: `width_64` is unchanged until the v wrap, then updates on the same edge as `frame_start`.
- Count a full frame:
  - 640×420 clocks between `frame_start` pulses.
  - `hsync` high 48 clocks from h_count 544.
  - `vsync` high on lines 400..403.
  - `de` high 512 clocks per active line, offset 6 from h_count 0.
- Assert `reset` mid-line (h_count≈300, v_count≈50): outputs go to reset values immediately; after release the frame restarts at 0/0.

Source files
------------

// File: rtl/vdg_pkg.sv
// Shared definitions for the text-mode video sequencer: display mode
// encodings, character-cell geometry, fetch-phase positions within a cell,
// counter widths and the cell-to-VRAM address helper.
package vdg_pkg;

  typedef enum logic {
    MODE_32 = 1'b0,   // 32 x 16 cells, 16 clocks x 24 lines
    MODE_64 = 1'b1    // 64 x 32 cells,  8 clocks x 12 lines
  } vdg_mode_e;

  localparam int unsigned ROW_LINES_32 = 24;
  localparam int unsigned ROW_LINES_64 = 12;
  localparam int unsigned CELL_CLKS_32 = 16;
  localparam int unsigned CELL_CLKS_64 = 8;

  // Positions within a cell, in clocks.
  localparam int unsigned PH_ADDR  = 0;  // vram_addr/vram_rd presented
  localparam int unsigned PH_LATCH = 1;  // char_code captured at the end of this clock
  localparam int unsigned PH_LOAD  = 5;  // character generator loads its ROM data

  localparam int unsigned H_CNT_W = 10;
  localparam int unsigned V_CNT_W = 9;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned LINE_W  = 5;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned CELL_AW = 11;

  // row*32+col or row*64+col built from shifts; only meaningful while
  // hpos is inside the active area.
  function automatic logic [CELL_AW-1:0] cell_addr(
    input vdg_mode_e          mode,
    input logic [ROW_W-1:0]   row,
    input logic [H_CNT_W-1:0] hpos
  );
    if (mode == MODE_64)
      return CELL_AW'({row, 6'b0}) | CELL_AW'(hpos >> 3);
    return CELL_AW'({row[3:0], 5'b0}) | CELL_AW'(hpos >> 4);
  endfunction

endpackage

// File: rtl/vdg_raster_counter.sv
// Raster timing for the text sequencer.
// Ports:
//   pixel_clock_i, reset_i   clock, asynchronous active-high reset
//   h_next_o                 horizontal position the next clock will show
//   line_wrap_o              the coming edge wraps h_count
//   frame_wrap_o             the coming edge wraps both h_count and v_count
//   active_next_o            active-area flag for the next clock
//   active_o                 registered active-area flag for this clock
//   hsync_o, vsync_o         registered active-high syncs
//   frame_start_o            registered pulse while h_count==0 && v_count==0
module vdg_raster_counter
  import vdg_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 512,
  parameter int unsigned H_TOTAL      = 640,
  parameter int unsigned H_SYNC_START = 544,
  parameter int unsigned H_SYNC_LEN   = 48,
  parameter int unsigned V_ACTIVE     = 384,
  parameter int unsigned V_TOTAL      = 420,
  parameter int unsigned V_SYNC_START = 400,
  parameter int unsigned V_SYNC_LEN   = 4
) (
  input  logic               pixel_clock_i,
  input  logic               reset_i,
  output logic [H_CNT_W-1:0] h_next_o,
  output logic               line_wrap_o,
  output logic               frame_wrap_o,
  output logic               active_next_o,
  output logic               active_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               frame_start_o
);

  logic               run_q;
  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;
  logic               active_q, active_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               fstart_q, fstart_d;
  logic               line_wrap, frame_wrap;

  // The first edge after reset holds the counters at 0/0 so that every
  // registered decode (including frame_start) is presented for position
  // 0/0 on the first clock after release; counting starts on the next edge.
  always_comb begin
    line_wrap  = run_q && (h_q == H_CNT_W'(H_TOTAL - 1));
    frame_wrap = line_wrap && (v_q == V_CNT_W'(V_TOTAL - 1));
    h_d        = h_q;
    v_d        = v_q;
    if (run_q) begin
      h_d = line_wrap ? '0 : h_q + H_CNT_W'(1);
      if (line_wrap)
        v_d = frame_wrap ? '0 : v_q + V_CNT_W'(1);
    end
    active_d = (h_d < H_CNT_W'(H_ACTIVE)) && (v_d < V_CNT_W'(V_ACTIVE));
    hsync_d  = (h_d >= H_CNT_W'(H_SYNC_START)) &&
               (h_d <  H_CNT_W'(H_SYNC_START + H_SYNC_LEN));
    vsync_d  = (v_d >= V_CNT_W'(V_SYNC_START)) &&
               (v_d <  V_CNT_W'(V_SYNC_START + V_SYNC_LEN));
    fstart_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge pixel_clock_i or posedge reset_i) begin
    if (reset_i) begin
      run_q    <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
    end
  end

  assign h_next_o      = h_d;
  assign line_wrap_o   = line_wrap;
  assign frame_wrap_o  = frame_wrap;
  assign active_next_o = active_d;
  assign active_o      = active_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = fstart_q;

endmodule

// File: rtl/vdg_text_fetch.sv
// Text-mode video sequencer feeding the character generator: runs the
// raster, fetches one character code per active cell from video RAM and
// presents char_code/subchar_line/subchar_pixel to the generator.
// Ports:
//   pixel_clock, reset       clock, asynchronous active-high reset
//   width_64_req             requested mode (1: 64x32, 0: 32x16)
//   vram_addr, vram_rd       registered RAM read address and strobe
//   vram_data                RAM data, valid one clock after vram_rd
//   char_code                latched character code
//   subchar_line             line within the character row
//   subchar_pixel            clock position within the cell
//   width_64                 mode in effect for the current frame
//   hsync, vsync             active-high syncs
//   de                       display enable aligned to generator pixel_on
//   frame_start              one-clock pulse at frame position 0/0
module vdg_text_fetch
  import vdg_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 512,
  parameter int unsigned H_TOTAL      = 640,
  parameter int unsigned H_SYNC_START = 544,
  parameter int unsigned H_SYNC_LEN   = 48,
  parameter int unsigned V_ACTIVE     = 384,
  parameter int unsigned V_TOTAL      = 420,
  parameter int unsigned V_SYNC_START = 400,
  parameter int unsigned V_SYNC_LEN   = 4,
  parameter int unsigned VRAM_AW      = 11,
  parameter int unsigned DE_DELAY     = PH_LOAD + 1
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               width_64_req,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_rd,
  input  logic [7:0]         vram_data,
  output logic [7:0]         char_code,
  output logic [4:0]         subchar_line,
  output logic [3:0]         subchar_pixel,
  output logic               width_64,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);

  logic [H_CNT_W-1:0] h_next;
  logic               line_wrap, frame_wrap;
  logic               active_next, active_q;

  vdg_raster_counter #(
    .H_ACTIVE     (H_ACTIVE),
    .H_TOTAL      (H_TOTAL),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_LEN   (H_SYNC_LEN),
    .V_ACTIVE     (V_ACTIVE),
    .V_TOTAL      (V_TOTAL),
    .V_SYNC_START (V_SYNC_START),
    .V_SYNC_LEN   (V_SYNC_LEN)
  ) u_raster (
    .pixel_clock_i (pixel_clock),
    .reset_i       (reset),
    .h_next_o      (h_next),
    .line_wrap_o   (line_wrap),
    .frame_wrap_o  (frame_wrap),
    .active_next_o (active_next),
    .active_o      (active_q),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .frame_start_o (frame_start)
  );

  vdg_mode_e             mode_q, mode_d;
  logic [LINE_W-1:0]     line_q, line_d, last_line;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [VRAM_AW-1:0]    addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [7:0]            char_q, char_d;
  logic [DE_DELAY-1:0]   de_sr_q, de_sr_d;

  // All per-cell outputs are computed from the next raster position so
  // they register in step with the counters.
  always_comb begin
    mode_d    = frame_wrap ? vdg_mode_e'(width_64_req) : mode_q;
    last_line = (mode_q == MODE_64) ? LINE_W'(ROW_LINES_64 - 1)
                                    : LINE_W'(ROW_LINES_32 - 1);
    line_d    = line_q;
    row_d     = row_q;
    if (frame_wrap) begin
      line_d = '0;
      row_d  = '0;
    end else if (line_wrap) begin
      if (line_q == last_line) begin
        line_d = '0;
        row_d  = row_q + ROW_W'(1);
      end else begin
        line_d = line_q + LINE_W'(1);
      end
    end

    pix_d  = (mode_d == MODE_64) ? PIX_W'(h_next & H_CNT_W'(CELL_CLKS_64 - 1))
                                 : PIX_W'(h_next & H_CNT_W'(CELL_CLKS_32 - 1));
    rd_d   = active_next && (pix_d == PIX_W'(PH_ADDR));
    addr_d = rd_d ? VRAM_AW'(cell_addr(mode_d, row_d, h_next)) : addr_q;

    // RAM data for the cell arrives during its latch clock.
    char_d  = (active_q && (pix_q == PIX_W'(PH_LATCH))) ? vram_data : char_q;
    de_sr_d = (de_sr_q << 1) | DE_DELAY'(active_q);
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_32;
      line_q  <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      char_q  <= '0;
      de_sr_q <= '0;
    end else begin
      mode_q  <= mode_d;
      line_q  <= line_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      char_q  <= char_d;
      de_sr_q <= de_sr_d;
    end
  end

  assign vram_addr     = addr_q;
  assign vram_rd       = rd_q;
  assign char_code     = char_q;
  assign subchar_line  = line_q;
  assign subchar_pixel = pix_q;
  assign width_64      = (mode_q == MODE_64);
  assign de            = de_sr_q[DE_DELAY-1];

endmodule
